// File: rtl/timer_sched_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_pkg
// Shared definitions for the timer scheduler:
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2w  : index width helper, never returns less than 1 bit
// -----------------------------------------------------------------------------
package timer_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Width of an index into n requesters; a 2-entry table still needs 1 bit.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/timer_down_counter.sv
// -----------------------------------------------------------------------------
// timer_down_counter
// Loadable down counter that saturates at zero.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load         : load load_val into the counter
//   load_val [W] : value to load
//   en           : decrement by one (ignored at zero)
//   clr          : force the counter to zero (highest priority)
//   count [W]    : registered count
//   expire       : combinational, count==1 while en is high
// -----------------------------------------------------------------------------
module timer_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         expire
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign count  = r_count;
   assign expire = en && (r_count == W'(1));

endmodule

// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
// Shares one down-counting timer between N requesters, round-robin arbitrated.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   enable          : 0 pauses countdown and blocks new grants
//   req   [N]       : request lines, held until done[i] or dropped to abort
//   dur   [N*W]     : per-requester interval, dur[i*W +: W]; 0 is treated as 1
//   grant [N]       : one-hot owner, high in RUN and DONE
//   done  [N]       : one-hot, one-cycle expiry pulse
//   busy            : timer owned
//   cur_id          : index of current owner
//   count [W]       : remaining count, 0 in IDLE
//   o_dbg_state     : current FSM state
//
// Handshake: a requester raises req[i] and holds it with dur stable until the
// grant edge. The interval is latched when grant[i] rises. Keeping req[i] high
// through RUN lets the interval run to completion, signalled by a single done[i]
// cycle (grant still high). Dropping req[i] during RUN aborts: grant falls on the
// next edge with no done. After every release the pointer moves past the owner,
// and at least one IDLE cycle separates consecutive grants.
// -----------------------------------------------------------------------------
module timer_scheduler
   import timer_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [N-1:0]           req,
   input  logic [N*W-1:0]         dur,
   output logic [N-1:0]           grant,
   output logic [N-1:0]           done,
   output logic                   busy,
   output logic [clog2w(N)-1:0]   cur_id,
   output logic [W-1:0]           count,
   output state_t                 o_dbg_state
);

   localparam int IW = clog2w(N);

   state_t          r_state;
   logic [IW-1:0]   r_cur_id;
   logic [IW-1:0]   r_rr_ptr;
   logic [N-1:0]    r_grant;
   logic [N-1:0]    r_done;
   logic            r_busy;

   logic [IW-1:0]   w_win_id;
   logic            w_found;
   logic            w_start;
   logic            w_abort;
   logic            w_cnt_en;
   logic            w_expire;
   logic [W-1:0]    w_dur_sel;
   logic [W-1:0]    w_load_val;
   logic [IW-1:0]   w_next_ptr;
   logic [W-1:0]    w_count;

   // Round-robin scan starting at the pointer; first set request wins.
   always_comb begin
      w_win_id = '0;
      w_found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(r_rr_ptr) + k) % N;
         if (!w_found && req[idx]) begin
            w_found  = 1'b1;
            w_win_id = IW'(idx);
         end
      end
   end

   assign w_start    = (r_state == S_IDLE) && enable && w_found;
   // Abort outranks expiry, so the counter is cleared rather than decremented.
   assign w_abort    = (r_state == S_RUN) && !req[r_cur_id];
   assign w_cnt_en   = (r_state == S_RUN) && enable && !w_abort;
   assign w_dur_sel  = dur[w_win_id*W +: W];
   assign w_load_val = (w_dur_sel == '0) ? W'(1) : w_dur_sel;
   assign w_next_ptr = (r_cur_id == IW'(N-1)) ? '0 : r_cur_id + 1'b1;

   timer_down_counter #(.W(W)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (w_start),
      .load_val (w_load_val),
      .en       (w_cnt_en),
      .clr      (w_abort),
      .count    (w_count),
      .expire   (w_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cur_id <= '0;
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_done   <= '0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= '0;
               if (w_start) begin
                  r_state  <= S_RUN;
                  r_cur_id <= w_win_id;
                  r_grant  <= {{(N-1){1'b0}}, 1'b1} << w_win_id;
                  r_busy   <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_abort) begin
                  r_state  <= S_IDLE;
                  r_grant  <= '0;
                  r_busy   <= 1'b0;
                  r_rr_ptr <= w_next_ptr;
               end else if (w_expire) begin
                  r_state <= S_DONE;
                  r_done  <= r_grant;
               end
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               r_grant  <= '0;
               r_done   <= '0;
               r_busy   <= 1'b0;
               r_rr_ptr <= w_next_ptr;
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= '0;
               r_done  <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign done        = r_done;
   assign busy        = r_busy;
   assign cur_id      = r_cur_id;
   assign count       = w_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_scheduler
// Directed bench for timer_scheduler (N=4, W=8). Expected done owners are queued
// when a served interval starts and popped when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_timer_scheduler;
   import timer_sched_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           reset;
   logic           enable;
   logic [N-1:0]   req;
   logic [N*W-1:0] dur;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic [1:0]     cur_id;
   logic [W-1:0]   count;
   state_t         dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] exp_q[$];

   timer_scheduler #(.N(N), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .req         (req),
      .dur         (dur),
      .grant       (grant),
      .done        (done),
      .busy        (busy),
      .cur_id      (cur_id),
      .count       (count),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dur(input int id, input int val);
      dur[id*W +: W] = W'(val);
   endtask

   // Serve one full interval for requester id whose effective duration is d.
   // Entered in an IDLE cycle with req[id] the next round-robin winner.
   task automatic serve(input int id, input int d);
      logic [N-1:0] oh;
      oh = 4'b0001 << id;
      exp_q.push_back(2'(id));
      tick();
      for (int c = 1; c <= d + 1; c++) begin
         check($sformatf("grant_r%0d_c%0d", id, c), grant, oh);
         check($sformatf("count_r%0d_c%0d", id, c), count, d + 1 - c);
         check($sformatf("done_r%0d_c%0d", id, c), done, (c == d + 1) ? oh : 4'b0000);
         check($sformatf("busy_r%0d_c%0d", id, c), busy, 1);
         if (c == 1) check($sformatf("cur_id_r%0d", id), cur_id, id);
         if (c <= d) tick();
      end
      req[id] = 1'b0;
      tick();
      check($sformatf("idle_grant_r%0d", id), grant, 0);
      check($sformatf("idle_busy_r%0d", id), busy, 0);
      check($sformatf("idle_done_r%0d", id), done, 0);
      check($sformatf("idle_count_r%0d", id), count, 0);
   endtask

   // scoreboard: every done pulse must match the oldest expected owner
   always @(negedge clk) begin
      if (done !== '0) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", done, 0);
         end else begin
            logic [N-1:0] e;
            e = 4'b0001 << exp_q.pop_front();
            check("sb_done_id", done, e);
         end
      end
   end

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      req    = '0;
      dur    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_cur_id", cur_id, 0);
      check("rst_count", count, 0);
      check("rst_state", dbg_state, S_IDLE);
      reset = 1'b0;

      // 1: single requester, dur=5
      enable = 1'b1;
      set_dur(0, 5);
      req = 4'b0001;
      serve(0, 5);

      // 2: all four request at once from rr_ptr=0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_dur(i, 3);
      req = 4'b1111;
      for (int i = 0; i < N; i++) serve(i, 3);

      // 3: fairness after a grant to 2
      set_dur(2, 2);
      req = 4'b0100;
      serve(2, 2);
      req = 4'b1001;
      serve(3, 3);
      serve(0, 3);

      // 4: zero duration loads as one
      set_dur(1, 0);
      req = 4'b0010;
      serve(1, 1);

      // 5: pause countdown with enable
      set_dur(0, 4);
      req = 4'b0001;
      exp_q.push_back(2'd0);
      tick();
      check("p_grant_c1", grant, 4'b0001);
      check("p_count_c1", count, 4);
      set_dur(0, 9);   // must not affect the latched interval
      tick();
      check("p_count_c2", count, 3);
      tick();
      check("p_count_c3", count, 2);
      enable = 1'b0;
      for (int c = 4; c <= 6; c++) begin
         tick();
         check($sformatf("p_hold_c%0d", c), count, 2);
         check($sformatf("p_hold_grant_c%0d", c), grant, 4'b0001);
         check($sformatf("p_hold_done_c%0d", c), done, 0);
      end
      enable = 1'b1;
      tick();
      check("p_count_c7", count, 1);
      check("p_done_c7", done, 0);
      tick();
      check("p_count_c8", count, 0);
      check("p_done_c8", done, 4'b0001);
      req = 4'b0000;
      tick();
      check("p_idle_grant", grant, 0);

      // 6a: enable=0 in IDLE blocks grants, then abort requester 1
      enable = 1'b0;
      set_dur(1, 6);
      set_dur(2, 2);
      req = 4'b0110;
      tick();
      check("blk_grant_1", grant, 0);
      tick();
      check("blk_busy_2", busy, 0);
      enable = 1'b1;
      tick();
      check("ab_grant", grant, 4'b0010);
      check("ab_count", count, 6);
      tick();
      check("ab_count_c2", count, 5);
      req[1] = 1'b0;
      tick();
      check("ab_grant_after", grant, 0);
      check("ab_busy_after", busy, 0);
      check("ab_count_after", count, 0);
      check("ab_done_after", done, 0);
      serve(2, 2);

      // 6b: asynchronous reset mid-RUN, then rr_ptr restarts at 0
      set_dur(3, 10);
      req = 4'b1000;
      tick();
      check("rr_grant3", grant, 4'b1000);
      tick();
      reset = 1'b1;
      #1;
      check("arst_grant", grant, 0);
      check("arst_done", done, 0);
      check("arst_busy", busy, 0);
      check("arst_cur_id", cur_id, 0);
      check("arst_count", count, 0);
      check("arst_state", dbg_state, S_IDLE);
      tick();
      reset = 1'b0;
      set_dur(0, 1);
      req = 4'b1001;
      serve(0, 1);
      req = 4'b0000;
      repeat (3) tick();

      check("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
